lenet_prod_accum: RTL



---
 rtl/lenet_prod_accum.sv | 110 +++++++++++
 1 files changed

// File: rtl/lenet_prod_accum.sv
// Product accumulator for the LeNet datapath: sums a stream of unsigned products per
// vector and hands the saturated sum, beat count and flags downstream over valid/ready.
// Optional requantizer to an 8-bit rounded value: define LENET_ACC_REQUANT_EN.
module lenet_prod_accum #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8,
  parameter int SHIFT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W:0]    out_count,
  output logic              out_ovf,
  output logic              out_trunc
);

  typedef enum logic {S_ACC, S_OUT} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_sticky;

  logic [ACC_W:0]     nxt;
  logic               beat_ovf;
  logic               vec_ovf;
  logic [ACC_W-1:0]   sum_sat;
  logic               at_limit;
  logic               close;
  logic [ACC_W-1:0]   sum_fmt;

  assign in_ready  = (state == S_ACC);
  assign out_valid = (state == S_OUT);

  // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    nxt      = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    beat_ovf = nxt[ACC_W];
    vec_ovf  = ovf_sticky | beat_ovf;
    // Once saturated, the vector stays pinned at all ones regardless of later beats.
    sum_sat  = vec_ovf ? '1 : nxt[ACC_W-1:0];
    at_limit = (cnt == '1);
    close    = in_last | at_limit;
  end

`ifdef LENET_ACC_REQUANT_EN
  localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SHIFT - 1);
  logic [ACC_W:0] rnd;

  // Round half up, then clamp to the 8-bit activation range; overflowed vectors clamp too.
  always_comb begin
    rnd = ({1'b0, sum_sat} + HALF) >> SHIFT;
    if (vec_ovf || (rnd > (ACC_W + 1)'(255)))
      sum_fmt = {{(ACC_W - 8){1'b0}}, 8'hFF};
    else
      sum_fmt = rnd[ACC_W-1:0];
  end
`else
  always_comb sum_fmt = sum_sat;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_ACC;
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      out_sum    <= '0;
      out_count  <= '0;
      out_ovf    <= 1'b0;
      out_trunc  <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (in_valid) begin
            if (close) begin
              out_sum    <= sum_fmt;
              out_count  <= {1'b0, cnt} + (CNT_W + 1)'(1);
              out_ovf    <= vec_ovf;
              out_trunc  <= ~in_last;
              acc        <= '0;
              cnt        <= '0;
              ovf_sticky <= 1'b0;
              state      <= S_OUT;
            end else begin
              acc        <= sum_sat;
              cnt        <= cnt + CNT_W'(1);
              ovf_sticky <= vec_ovf;
            end
          end
        end
        S_OUT: begin
          // Result fields hold here until the consumer takes them; input beats wait.
          if (out_ready)
            state <= S_ACC;
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule
